seven_seg_scanner: RTL and testbench

Time-multiplexed anode scanner: the driving end of the 4-digit display bus. It generates the rotating active-low anode pattern and the matching selected nibble, which feed the per-digit segment decoder. Operands A, B, AplusB and AminusB are double-buffered so that a new value is only shown at a frame boundary. Guard cycles at the start of each digit slot blank the display to prevent ghosting while the segments settle.

---
 rtl/seven_seg_scanner.sv | 139 +++++++++++++
 tb/tb_seven_seg_scanner.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/seven_seg_scanner.sv
// Four-digit anode scanner with double-buffered operands and per-slot guard blanking.
// Define SCAN_DP_EN to add a buffered, active-low decimal-point output.
module seven_seg_scanner #(
  parameter int unsigned REFRESH_DIV = 100000,
  parameter int unsigned GUARD       = 2,
  parameter int unsigned CNT_W       = 17
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic [3:0] AplusB,
  input  logic [3:0] AminusB,
  input  logic       load,
  input  logic [3:0] digit_en,
`ifdef SCAN_DP_EN
  input  logic [3:0] dp_in,
  output logic       dp,
`endif
  output logic [3:0] anode,
  output logic [3:0] digit,
  output logic       frame_tick
);

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_GUARD = CNT_W'(GUARD);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       idx_q, idx_d;
  logic [3:0][3:0]  active_q, active_d;
  logic [3:0][3:0]  pending_q, pending_d;
  logic             pending_valid_q, pending_valid_d;
  logic [3:0]       anode_q, anode_d;
  logic [3:0]       digit_q, digit_d;
  logic             frame_tick_q, frame_tick_d;
  logic             wrap;
  logic             lit;

`ifdef SCAN_DP_EN
  logic [3:0] dp_active_q, dp_active_d;
  logic [3:0] dp_pending_q, dp_pending_d;
  logic       dp_q, dp_d;
`endif

  // Prescaler, slot index, buffers and output next-state; outputs use post-edge state.
  always_comb begin
    cnt_d           = cnt_q + CNT_W'(1);
    idx_d           = idx_q;
    active_d        = active_q;
    pending_d       = pending_q;
    pending_valid_d = pending_valid_q;
    wrap            = 1'b0;
`ifdef SCAN_DP_EN
    dp_active_d     = dp_active_q;
    dp_pending_d    = dp_pending_q;
`endif

    if (cnt_q == CNT_LAST) begin
      cnt_d = '0;
      idx_d = 2'(idx_q + 2'd1);
      wrap  = (idx_q == 2'd3);
    end

    // Commit first so a load on the wrap edge lands in pending for the next frame.
    if (wrap && pending_valid_q) begin
      active_d        = pending_q;
      pending_valid_d = 1'b0;
`ifdef SCAN_DP_EN
      dp_active_d     = dp_pending_q;
`endif
    end

    if (load) begin
      pending_d       = {AminusB, AplusB, B, A};
      pending_valid_d = 1'b1;
`ifdef SCAN_DP_EN
      dp_pending_d    = dp_in;
`endif
    end

    lit = (cnt_d >= CNT_GUARD) && digit_en[idx_d];

    anode_d = 4'b1111;
    if (lit) begin
      case (idx_d)
        2'd0:    anode_d = 4'b1110;
        2'd1:    anode_d = 4'b1101;
        2'd2:    anode_d = 4'b1011;
        default: anode_d = 4'b0111;
      endcase
    end

    digit_d      = active_d[idx_d];
    frame_tick_d = wrap;
`ifdef SCAN_DP_EN
    dp_d         = lit ? ~dp_active_d[idx_d] : 1'b1;
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q           <= '0;
      idx_q           <= '0;
      active_q        <= '0;
      pending_q       <= '0;
      pending_valid_q <= 1'b0;
      anode_q         <= 4'b1111;
      digit_q         <= '0;
      frame_tick_q    <= 1'b0;
`ifdef SCAN_DP_EN
      dp_active_q     <= '0;
      dp_pending_q    <= '0;
      dp_q            <= 1'b1;
`endif
    end else begin
      cnt_q           <= cnt_d;
      idx_q           <= idx_d;
      active_q        <= active_d;
      pending_q       <= pending_d;
      pending_valid_q <= pending_valid_d;
      anode_q         <= anode_d;
      digit_q         <= digit_d;
      frame_tick_q    <= frame_tick_d;
`ifdef SCAN_DP_EN
      dp_active_q     <= dp_active_d;
      dp_pending_q    <= dp_pending_d;
      dp_q            <= dp_d;
`endif
    end
  end

  assign anode      = anode_q;
  assign digit      = digit_q;
  assign frame_tick = frame_tick_q;
`ifdef SCAN_DP_EN
  assign dp         = dp_q;
`endif

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Directed bench for seven_seg_scanner with REFRESH_DIV=4, GUARD=1.
// Covers SCAN_DP_EN checks when that macro is defined.
module tb_seven_seg_scanner;

  localparam int unsigned RDIV = 4;
  localparam int unsigned GRD  = 1;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] A, B, AplusB, AminusB;
  logic       load;
  logic [3:0] digit_en;
  logic [3:0] anode, digit;
  logic       frame_tick;
`ifdef SCAN_DP_EN
  logic [3:0] dp_in;
  logic       dp;
`endif

  seven_seg_scanner #(.REFRESH_DIV(RDIV), .GUARD(GRD), .CNT_W(3)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .A          (A),
    .B          (B),
    .AplusB     (AplusB),
    .AminusB    (AminusB),
    .load       (load),
    .digit_en   (digit_en),
`ifdef SCAN_DP_EN
    .dp_in      (dp_in),
    .dp         (dp),
`endif
    .anode      (anode),
    .digit      (digit),
    .frame_tick (frame_tick)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] en;
    logic       ld;
    logic [3:0] exp_anode;
    logic [3:0] exp_digit;
    logic       exp_tick;
  } vec_t;

  vec_t       vec [16];
  int         n_checks = 0;
  int         n_fail   = 0;
  int         e        = 0;
  logic [3:0] exp_act [4];
  logic [3:0] exp_dp;
  logic [3:0] slot_an [4];

  task automatic cmp(input string name, input logic [3:0] act, input logic [3:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s at edge %0d: got %b, expected %b", name, e, act, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    e++;
  endtask

  // Expected outputs from the edge count since reset release.
  task automatic chk(input string tag);
    int         c;
    int         ix;
    logic [3:0] an;
    logic       lit;
    c   = e % int'(RDIV);
    ix  = (e / int'(RDIV)) % 4;
    lit = (c >= int'(GRD)) && digit_en[ix];
    an  = lit ? slot_an[ix] : 4'b1111;
    cmp({tag, "_anode"}, anode, an);
    cmp({tag, "_digit"}, digit, exp_act[ix]);
    cmp({tag, "_tick"}, {3'b0, frame_tick}, {3'b0, (c == 0 && ix == 0)});
`ifdef SCAN_DP_EN
    cmp({tag, "_dp"}, {3'b0, dp}, {3'b0, lit ? ~exp_dp[ix] : 1'b1});
`endif
  endtask

  task automatic run_until(input int target, input string tag);
    while (e < target) begin
      step();
      chk(tag);
    end
  endtask

  task automatic set_ops(input logic [3:0] a, input logic [3:0] b,
                         input logic [3:0] s, input logic [3:0] d, input logic [3:0] p);
    A = a; B = b; AplusB = s; AminusB = d;
`ifdef SCAN_DP_EN
    dp_in = p;
`else
    if (p != 4'b0) ;
`endif
  endtask

  initial begin
    slot_an = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    vec[0]  = '{4'b1111, 1'b0, 4'b1110, 4'h0, 1'b0};
    vec[1]  = '{4'b1111, 1'b0, 4'b1110, 4'h0, 1'b0};
    vec[2]  = '{4'b1111, 1'b0, 4'b1110, 4'h0, 1'b0};
    vec[3]  = '{4'b1111, 1'b0, 4'b1111, 4'h0, 1'b0};
    vec[4]  = '{4'b1111, 1'b0, 4'b1101, 4'h0, 1'b0};
    vec[5]  = '{4'b1111, 1'b0, 4'b1101, 4'h0, 1'b0};
    vec[6]  = '{4'b1111, 1'b0, 4'b1101, 4'h0, 1'b0};
    vec[7]  = '{4'b1111, 1'b0, 4'b1111, 4'h0, 1'b0};
    vec[8]  = '{4'b1111, 1'b0, 4'b1011, 4'h0, 1'b0};
    vec[9]  = '{4'b1111, 1'b0, 4'b1011, 4'h0, 1'b0};
    vec[10] = '{4'b1111, 1'b0, 4'b1011, 4'h0, 1'b0};
    vec[11] = '{4'b1111, 1'b0, 4'b1111, 4'h0, 1'b0};
    vec[12] = '{4'b1111, 1'b0, 4'b0111, 4'h0, 1'b0};
    vec[13] = '{4'b1111, 1'b0, 4'b0111, 4'h0, 1'b0};
    vec[14] = '{4'b1111, 1'b0, 4'b0111, 4'h0, 1'b0};
    vec[15] = '{4'b1111, 1'b0, 4'b1111, 4'h0, 1'b1};

    rst_n    = 1'b0;
    load     = 1'b0;
    digit_en = 4'b1111;
    set_ops(4'h0, 4'h0, 4'h0, 4'h0, 4'b0000);
    exp_act  = '{4'h0, 4'h0, 4'h0, 4'h0};
    exp_dp   = 4'b0000;

    step();
    step();
    cmp("rst_anode", anode, 4'b1111);
    cmp("rst_digit", digit, 4'h0);
    cmp("rst_tick", {3'b0, frame_tick}, 4'b0);
`ifdef SCAN_DP_EN
    cmp("rst_dp", {3'b0, dp}, 4'b0001);
`endif
    rst_n = 1'b1;
    e     = 0;

    // Rotation and guard from the vector table.
    for (int i = 0; i < 16; i++) begin
      digit_en = vec[i].en;
      load     = vec[i].ld;
      step();
      cmp("rot_anode", anode, vec[i].exp_anode);
      cmp("rot_digit", digit, vec[i].exp_digit);
      cmp("rot_tick", {3'b0, frame_tick}, {3'b0, vec[i].exp_tick});
    end

    // Mid-frame load stays hidden until the next wrap.
    run_until(22, "pre");
    set_ops(4'h3, 4'h5, 4'h8, 4'hE, 4'b0100);
    load = 1'b1;
    step();
    chk("ld");
    load = 1'b0;
    set_ops(4'h0, 4'h0, 4'h0, 4'h0, 4'b0000);
    run_until(31, "hold");
    exp_act = '{4'h3, 4'h5, 4'h8, 4'hE};
    exp_dp  = 4'b0100;
    run_until(36, "show");

    // Load landing on the wrap edge commits one frame later.
    set_ops(4'h1, 4'h0, 4'h0, 4'h0, 4'b0000);
    load = 1'b1;
    step();
    chk("ld1");
    load = 1'b0;
    run_until(47, "old");
    set_ops(4'h2, 4'h0, 4'h0, 4'h0, 4'b0000);
    load    = 1'b1;
    exp_act = '{4'h1, 4'h0, 4'h0, 4'h0};
    exp_dp  = 4'b0000;
    step();
    chk("wrapld");
    load = 1'b0;
    run_until(63, "a1");
    exp_act = '{4'h2, 4'h0, 4'h0, 4'h0};
    run_until(79, "a2");

    // Per-digit blanking for one full frame.
    digit_en = 4'b1010;
    run_until(95, "blank");
    digit_en = 4'b1111;

    // Reset mid-slot with a load pending discards the pending data.
    set_ops(4'h9, 4'h9, 4'h9, 4'h9, 4'b1111);
    run_until(100, "pre2");
    load = 1'b1;
    step();
    chk("ld9");
    load = 1'b0;
    run_until(107, "pend");
    rst_n = 1'b0;
    step();
    cmp("mrst_anode", anode, 4'b1111);
    cmp("mrst_digit", digit, 4'h0);
    cmp("mrst_tick", {3'b0, frame_tick}, 4'b0);
    rst_n   = 1'b1;
    e       = 0;
    exp_act = '{4'h0, 4'h0, 4'h0, 4'h0};
    exp_dp  = 4'b0000;
    run_until(32, "post");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
